// File: rtl/ex_mem_wb_pipeline.sv
// ex_mem_wb_pipeline
//   EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core together
//   with the data-memory access controller. A load or store held in the
//   EX/MEM slot raises dmem_req. The upstream stages stay frozen (mem_stall)
//   until dmem_ack arrives, and bubbles are fed into MEM/WB meanwhile.
//
//   Optional feature macro: DMEM_TIMEOUT_EN
//     defined   - an access still waiting when the wait counter reaches
//                 TIMEOUT is aborted, and the sticky dmem_err flag is set.
//     undefined - accesses wait indefinitely and dmem_err is tied to 0.
//
//   Handshake: dmem_req/dmem_ack form a strict valid/ready pair. dmem_req
//   and the address/data/we fields stay stable from the first request cycle
//   until (and including) the cycle where dmem_ack is high. The access
//   completes on the edge that ends the ack cycle, and dmem_rdata is
//   captured only in that cycle.
//
//   fsm_state and wait_count expose the controller state for observation.

module ex_mem_wb_pipeline #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              flush_ex,
    input  logic              ex_RegWrite,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_MemtoReg,
    input  logic [REG_AW-1:0] ex_Rd,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              EX_MEM_RegWrite,
    output logic [REG_AW-1:0] EX_MEM_Rd,
    output logic [DATA_W-1:0] EX_MEM_result,
    output logic              MEM_WB_RegWrite,
    output logic [REG_AW-1:0] MEM_WB_Rd,
    output logic [DATA_W-1:0] MEM_WB_wdata,
    output logic              dmem_err,
    output logic              fsm_state,
    output logic [3:0]        wait_count
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
`ifdef DMEM_TIMEOUT_EN
    localparam logic TIMEOUT_ON = 1'b1;
`else
    localparam logic TIMEOUT_ON = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             abort;

    // EX/MEM slot
    logic              em_valid;
    logic              em_regwrite;
    logic              em_memread;
    logic              em_memwrite;
    logic              em_memtoreg;
    logic [REG_AW-1:0] em_rd;
    logic [DATA_W-1:0] em_result;
    logic [DATA_W-1:0] em_store_data;

    // MEM/WB slot
    logic              mw_valid;
    logic              mw_regwrite;
    logic [REG_AW-1:0] mw_rd;
    logic [DATA_W-1:0] mw_wdata;

    logic memop;
    logic advance;
    logic ex_take;

    assign memop   = em_valid & (em_memread | em_memwrite);
    // An abort frees the slot in the same way as an ack, but with no data.
    assign mem_stall = memop & ~dmem_ack & ~abort;
    assign advance   = ~mem_stall;
    // flush_ex is only acted upon when the slot actually advances.
    assign ex_take   = ex_valid & ~flush_ex;

    assign dmem_req   = memop;
    assign dmem_we    = memop & em_memwrite;
    assign dmem_addr  = em_result;
    assign dmem_wdata = em_store_data;

    assign EX_MEM_RegWrite = em_valid & em_regwrite;
    assign EX_MEM_Rd       = em_rd;
    assign EX_MEM_result   = em_result;
    assign MEM_WB_RegWrite = mw_valid & mw_regwrite;
    assign MEM_WB_Rd       = mw_rd;
    assign MEM_WB_wdata    = mw_wdata;

    assign fsm_state  = state;
    assign wait_count = cnt;

    // Access controller state register and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: enter WAIT on an unacknowledged access, leave on ack or timeout
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memop && !dmem_ack) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt != CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end
                if (dmem_ack) begin
                    state_next = ST_IDLE;
                end else if (TIMEOUT_ON && memop && (cnt == TIMEOUT_CNT)) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // EX/MEM register: load EX (or a bubble) when advancing, hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            em_valid      <= 1'b0;
            em_regwrite   <= 1'b0;
            em_memread    <= 1'b0;
            em_memwrite   <= 1'b0;
            em_memtoreg   <= 1'b0;
            em_rd         <= '0;
            em_result     <= '0;
            em_store_data <= '0;
        end else if (advance) begin
            if (ex_take) begin
                em_valid      <= 1'b1;
                em_regwrite   <= ex_RegWrite;
                em_memread    <= ex_MemRead;
                em_memwrite   <= ex_MemWrite;
                em_memtoreg   <= ex_MemtoReg;
                em_rd         <= ex_Rd;
                em_result     <= ex_alu_result;
                em_store_data <= ex_store_data;
            end else begin
                em_valid      <= 1'b0;
                em_regwrite   <= 1'b0;
                em_memread    <= 1'b0;
                em_memwrite   <= 1'b0;
                em_memtoreg   <= 1'b0;
                em_rd         <= '0;
                em_result     <= '0;
                em_store_data <= '0;
            end
        end
    end

    // MEM/WB register: take the EX/MEM slot on a normal advance, otherwise a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw_valid    <= 1'b0;
            mw_regwrite <= 1'b0;
            mw_rd       <= '0;
            mw_wdata    <= '0;
        end else if (advance && !abort && em_valid) begin
            mw_valid    <= 1'b1;
            mw_regwrite <= em_regwrite;
            mw_rd       <= em_rd;
            mw_wdata    <= em_memtoreg ? dmem_rdata : em_result;
        end else begin
            mw_valid    <= 1'b0;
            mw_regwrite <= 1'b0;
            mw_rd       <= '0;
            mw_wdata    <= '0;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    logic err_q;

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign dmem_err = err_q;
`else
    assign dmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipeline.sv
// tb_ex_mem_wb_pipeline
//   Directed vectors with hand-computed expected values for the EX/MEM and
//   MEM/WB pipeline registers and the data-memory access controller.
//   Inputs change 1 time unit after a rising edge. Outputs are checked at
//   the falling edge.

module tb_ex_mem_wb_pipeline;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic              ex_valid;
    logic              flush_ex;
    logic              ex_RegWrite;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_MemtoReg;
    logic [REG_AW-1:0] ex_Rd;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              mem_stall;
    logic              EX_MEM_RegWrite;
    logic [REG_AW-1:0] EX_MEM_Rd;
    logic [DATA_W-1:0] EX_MEM_result;
    logic              MEM_WB_RegWrite;
    logic [REG_AW-1:0] MEM_WB_Rd;
    logic [DATA_W-1:0] MEM_WB_wdata;
    logic              dmem_err;
    logic              fsm_state;
    logic [3:0]        wait_count;

    ex_mem_wb_pipeline #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .TIMEOUT(15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .flush_ex       (flush_ex),
        .ex_RegWrite    (ex_RegWrite),
        .ex_MemRead     (ex_MemRead),
        .ex_MemWrite    (ex_MemWrite),
        .ex_MemtoReg    (ex_MemtoReg),
        .ex_Rd          (ex_Rd),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .mem_stall      (mem_stall),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_Rd      (EX_MEM_Rd),
        .EX_MEM_result  (EX_MEM_result),
        .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_Rd      (MEM_WB_Rd),
        .MEM_WB_wdata   (MEM_WB_wdata),
        .dmem_err       (dmem_err),
        .fsm_state      (fsm_state),
        .wait_count     (wait_count)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic v, input logic rw, input logic mr, input logic mw,
                            input logic m2r, input logic [REG_AW-1:0] rd,
                            input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] st);
        ex_valid      = v;
        ex_RegWrite   = rw;
        ex_MemRead    = mr;
        ex_MemWrite   = mw;
        ex_MemtoReg   = m2r;
        ex_Rd         = rd;
        ex_alu_result = alu;
        ex_store_data = st;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},      32'(dmem_req), 32'd0);
        check({tag, "_stall"},    32'(mem_stall), 32'd0);
        check({tag, "_em_rw"},    32'(EX_MEM_RegWrite), 32'd0);
        check({tag, "_em_rd"},    32'(EX_MEM_Rd), 32'd0);
        check({tag, "_em_res"},   EX_MEM_result, 32'd0);
        check({tag, "_mw_rw"},    32'(MEM_WB_RegWrite), 32'd0);
        check({tag, "_mw_rd"},    32'(MEM_WB_Rd), 32'd0);
        check({tag, "_mw_wdata"}, MEM_WB_wdata, 32'd0);
        check({tag, "_err"},      32'(dmem_err), 32'd0);
        check({tag, "_state"},    32'(fsm_state), 32'd0);
        check({tag, "_cnt"},      32'(wait_count), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int n;

    initial begin
        rst        = 1'b1;
        flush_ex   = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        idle_ex();
        #1 rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // add r3 = 0x10, followed directly by lw r5 from 0x80
        drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h10, 32'h0);
        tick();
        settle();
        check("add_em_rw",  32'(EX_MEM_RegWrite), 32'd1);
        check("add_em_rd",  32'(EX_MEM_Rd), 32'd3);
        check("add_em_res", EX_MEM_result, 32'h10);
        check("add_em_req", 32'(dmem_req), 32'd0);
        tick();
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h80, 32'h0);
        tick();
        // add r7 = 0x77 waits in EX behind the load
        drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77, 32'h0);
        settle();
        check("add_mw_rw",    32'(MEM_WB_RegWrite), 32'd1);
        check("add_mw_rd",    32'(MEM_WB_Rd), 32'd3);
        check("add_mw_wdata", MEM_WB_wdata, 32'h10);
        check("lw_req",       32'(dmem_req), 32'd1);
        check("lw_we",        32'(dmem_we), 32'd0);
        check("lw_addr",      dmem_addr, 32'h80);
        check("lw_stall1",    32'(mem_stall), 32'd1);
        tick();
        settle();
        check("lw_stall2",     32'(mem_stall), 32'd1);
        check("lw_bubble_rw",  32'(MEM_WB_RegWrite), 32'd0);
        check("lw_bubble_rd",  32'(MEM_WB_Rd), 32'd0);
        check("lw_hold_rd",    32'(EX_MEM_Rd), 32'd5);
        check("lw_state_wait", 32'(fsm_state), 32'd1);
        check("lw_cnt0",       32'(wait_count), 32'd0);
        tick();
        settle();
        check("lw_stall3", 32'(mem_stall), 32'd1);
        check("lw_cnt1",   32'(wait_count), 32'd1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE;
        settle();
        check("lw_ack_nostall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        idle_ex();
        settle();
        check("lw_mw_rw",    32'(MEM_WB_RegWrite), 32'd1);
        check("lw_mw_rd",    32'(MEM_WB_Rd), 32'd5);
        check("lw_mw_wdata", MEM_WB_wdata, 32'hCAFE);
        check("add7_em_rd",  32'(EX_MEM_Rd), 32'd7);
        check("add7_em_res", EX_MEM_result, 32'h77);
        check("lw_state_idle", 32'(fsm_state), 32'd0);

        // sw 0x55 -> [0x40], acknowledged in its first cycle
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h40, 32'h55);
        tick();
        idle_ex();
        dmem_ack = 1'b1;
        settle();
        check("add7_mw_rd",    32'(MEM_WB_Rd), 32'd7);
        check("add7_mw_wdata", MEM_WB_wdata, 32'h77);
        check("sw_req",   32'(dmem_req), 32'd1);
        check("sw_we",    32'(dmem_we), 32'd1);
        check("sw_addr",  dmem_addr, 32'h40);
        check("sw_wdata", dmem_wdata, 32'h55);
        check("sw_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        settle();
        check("sw_mw_rw", 32'(MEM_WB_RegWrite), 32'd0);
        check("sw_state", 32'(fsm_state), 32'd0);
        check("sw_req_done", 32'(dmem_req), 32'd0);

        // lw r9 with flush_ex during the stall and again with the ack
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h90, 32'h0);
        tick();
        drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'hA0, 32'h0);
        flush_ex = 1'b1;
        settle();
        check("fl_stall1", 32'(mem_stall), 32'd1);
        tick();
        settle();
        check("fl_ignored_rd", 32'(EX_MEM_Rd), 32'd9);
        check("fl_stall2",     32'(mem_stall), 32'd1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234;
        settle();
        check("fl_ack_nostall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        flush_ex   = 1'b0;
        idle_ex();
        settle();
        check("fl_em_rw",    32'(EX_MEM_RegWrite), 32'd0);
        check("fl_em_rd",    32'(EX_MEM_Rd), 32'd0);
        check("fl_em_req",   32'(dmem_req), 32'd0);
        check("fl_mw_rd",    32'(MEM_WB_Rd), 32'd9);
        check("fl_mw_wdata", MEM_WB_wdata, 32'h1234);

`ifdef DMEM_TIMEOUT_EN
        // lw r11 never acknowledged: abort after 15 WAIT cycles
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'hB0, 32'h0);
        tick();
        drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'hC0, 32'h0);
        settle();
        n = 0;
        while (mem_stall && n < 40) begin
            n++;
            tick();
            settle();
        end
        check("to_stall_cycles", 32'(n), 32'd16);
        check("to_err_before",   32'(dmem_err), 32'd0);
        tick();
        idle_ex();
        settle();
        check("to_err_set",   32'(dmem_err), 32'd1);
        check("to_mw_bubble", 32'(MEM_WB_RegWrite), 32'd0);
        check("to_state",     32'(fsm_state), 32'd0);
        check("to_resume_rd", 32'(EX_MEM_Rd), 32'd12);
        tick();
        settle();
        check("to_err_sticky", 32'(dmem_err), 32'd1);
        check("to_mw_rd",      32'(MEM_WB_Rd), 32'd12);
        check("to_mw_wdata",   MEM_WB_wdata, 32'hC0);
`else
        // lw r11 with a long wait: counter saturates, no timeout
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'hB0, 32'h0);
        tick();
        idle_ex();
        settle();
        check("sat_stall_first", 32'(mem_stall), 32'd1);
        tick();
        for (int i = 0; i < 18; i++) tick();
        settle();
        check("sat_cnt",   32'(wait_count), 32'd15);
        check("sat_stall", 32'(mem_stall), 32'd1);
        check("sat_err",   32'(dmem_err), 32'd0);
        check("sat_state", 32'(fsm_state), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBEEF;
        #1;
        check("sat_ack_nostall", 32'(mem_stall), 32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        settle();
        check("sat_mw_rd",    32'(MEM_WB_Rd), 32'd11);
        check("sat_mw_wdata", MEM_WB_wdata, 32'hBEEF);
`endif

        // reset asserted while a load is pending
        drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'hD0, 32'h0);
        tick();
        idle_ex();
        settle();
        check("rstw_stall_before", 32'(mem_stall), 32'd1);
        tick();
        settle();
        rst = 1'b0;
        #1;
        check_all_zero("rst_wait");
        tick();
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
